// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, F/D register layout and helpers for the
//               P5 pipeline. The FETCH_ADEL_CHECK_EN macro adds an
//               address-error flag to the F/D record.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // PC after reset; also the base address of the instruction memory
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  // Instruction memory depth in words
  localparam int unsigned IM_WORDS  = 4096;
  // Bubble encoding (sll $0,$0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  // Exception code for an address error on instruction fetch
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  // One past the last valid fetch address, kept 33 bits wide so the
  // comparison cannot wrap even if the memory reaches the top of the map
  localparam logic [32:0] IM_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  // Contents of the F/D pipeline register
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
`ifdef FETCH_ADEL_CHECK_EN
    logic        exc_adel;
`endif
  } fd_t;

  localparam int FD_W = $bits(fd_t);

  // Bubble record tagged with the PC it replaces; link address kept
  // consistent with the PC field
  function automatic fd_t fd_bubble(input logic [31:0] pc);
    fd_t b;
    b          = '0;
    b.instr    = NOP_INSTR;
    b.pc       = pc;
    b.pc8      = pc + 32'd8;
    b.valid    = 1'b0;
    return b;
  endfunction

  // Reset contents of F/D
  localparam fd_t FD_RST = fd_bubble(RESET_PC);

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fd_reg.sv
`default_nettype none
// ============================================================================
// Module      : fd_reg
// Description : Generic pipeline register with asynchronous reset, flush
//               (loads a caller-supplied bubble) and stall (hold). Flush
//               takes priority over stall. Shared by F/D, D/E and E/M.
// Revision    : 1.0 - initial release
// ============================================================================
module fd_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_bubble,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_flush) begin
      r_q <= i_bubble;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : fd_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : IF stage of the P5 pipeline. Holds the PC, presents it to the
//               combinational instruction ROM and captures the returned word
//               into the F/D register. Branches resolve in D with one delay
//               slot, so a redirect never discards the instruction in F.
//               Optional macro FETCH_ADEL_CHECK_EN adds D_ExcAdEL, flagging
//               misaligned or out-of-memory fetch addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  input  logic        D_flush,
  input  logic        D_redirect,
  input  logic [31:0] D_target,
  output logic [31:0] F_IM_PC,
  input  logic [31:0] F_IM_Instr,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
`ifdef FETCH_ADEL_CHECK_EN
  output logic        D_ExcAdEL,
`endif
  output logic        D_valid
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  fd_t         w_fd_d;
  fd_t         w_fd_bubble;
  fd_t         w_fd_q;

`ifdef FETCH_ADEL_CHECK_EN
  logic        w_adel;

  // Fetch address error: misaligned, below the IM base or past its end
  always_comb begin
    w_adel = (r_pc[1:0] != 2'b00)
          || ({1'b0, r_pc} <  {1'b0, RESET_PC})
          || ({1'b0, r_pc} >= IM_END);
  end
`endif

  // Next-PC mux: stall holds (a redirect seen during a stall is re-presented
  // later), otherwise redirect target, otherwise sequential with natural wrap
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (F_stall) begin
      w_pc_next = r_pc;
    end else if (D_redirect) begin
      w_pc_next = D_target;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Record captured into F/D for a normal fetch; a faulting fetch carries a
  // NOP so nothing architectural executes, but stays valid so the exception
  // is taken downstream
  always_comb begin
    w_fd_d       = '0;
    w_fd_d.instr = F_IM_Instr;
    w_fd_d.pc    = r_pc;
    w_fd_d.pc8   = r_pc + 32'd8;
    w_fd_d.valid = 1'b1;
`ifdef FETCH_ADEL_CHECK_EN
    w_fd_d.exc_adel = w_adel;
    if (w_adel) begin
      w_fd_d.instr = NOP_INSTR;
    end
`endif
  end

  // Bubble loaded on flush, tagged with the PC currently in F
  always_comb begin
    w_fd_bubble = fd_bubble(r_pc);
  end

  fd_reg #(
    .W       (FD_W),
    .RST_VAL (FD_RST)
  ) u_fd_reg (
    .clk      (clk),
    .rst      (reset),
    .i_stall  (F_stall),
    .i_flush  (D_flush),
    .i_d      (w_fd_d),
    .i_bubble (w_fd_bubble),
    .o_q      (w_fd_q)
  );

  assign F_IM_PC = r_pc;
  assign D_Instr = w_fd_q.instr;
  assign D_PC    = w_fd_q.pc;
  assign D_PC8   = w_fd_q.pc8;
  assign D_valid = w_fd_q.valid;
`ifdef FETCH_ADEL_CHECK_EN
  assign D_ExcAdEL = w_fd_q.exc_adel;
`endif

endmodule : fetch_stage
`default_nettype wire
